// File: rtl/phy_rx_deser_align_pkg.sv
// ---------------------------------------------------------------------------
// phy_rx_deser_align_pkg : shared COM default and lane FSM encoding. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package phy_rx_deser_align_pkg;

   localparam logic [7:0] COM_DEFAULT = 8'hBC;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } lane_state_t;

endpackage

`default_nettype wire

// File: rtl/phy_rx_deser_align_lane.sv
// ---------------------------------------------------------------------------
// phy_rx_lane : one serial lane, COM-aligned deserializer with lock FSM. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module phy_rx_lane
   import phy_rx_deser_align_pkg::*;
#(
   parameter int           W            = 8,
   parameter logic [W-1:0] COM          = W'(COM_DEFAULT),
   parameter int           LOCK_COMS    = 4,
   parameter int           MISALIGN_MAX = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_bit,
   output logic [W-1:0] o_word,
   output logic         o_valid,
   output logic         o_strobe,
   output logic         o_active
);

   localparam int BW = $clog2(W);
   localparam int CW = $clog2(LOCK_COMS + 1);
   localparam int MW = $clog2(MISALIGN_MAX + 1);
   localparam logic [BW-1:0] c_last_bit = BW'(W - 1);
   localparam logic [CW-1:0] c_com_sat  = CW'(LOCK_COMS);
   localparam logic [MW-1:0] c_mis_sat  = MW'(MISALIGN_MAX);

   lane_state_t   r_state, w_state_d;
   logic [W-1:0]  r_sr, w_nxt;
   logic [BW-1:0] r_bit_cnt, w_bit_cnt_d;
   logic [CW-1:0] r_com_cnt, w_com_cnt_d, w_com_inc;
   logic [MW-1:0] r_mis_cnt, w_mis_cnt_d, w_mis_inc;
   logic [W-1:0]  r_word, w_word_d;
   logic          r_valid, w_valid_d;
   logic          r_strobe, w_strobe_d;
   logic          w_boundary, w_is_com;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= HUNT;
         r_sr      <= '0;
         r_bit_cnt <= '0;
         r_com_cnt <= '0;
         r_mis_cnt <= '0;
         r_word    <= '0;
         r_valid   <= 1'b0;
         r_strobe  <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_sr      <= w_nxt;
         r_bit_cnt <= w_bit_cnt_d;
         r_com_cnt <= w_com_cnt_d;
         r_mis_cnt <= w_mis_cnt_d;
         r_word    <= w_word_d;
         r_valid   <= w_valid_d;
         r_strobe  <= w_strobe_d;
      end
   end

   always_comb begin
      w_nxt       = {r_sr[W-2:0], i_bit};
      w_boundary  = (r_bit_cnt == c_last_bit);
      w_is_com    = (w_nxt == COM);
      w_com_inc   = r_com_cnt + CW'(1);
      w_mis_inc   = r_mis_cnt + MW'(1);
      w_state_d   = r_state;
      w_bit_cnt_d = w_boundary ? '0 : r_bit_cnt + BW'(1);
      w_com_cnt_d = r_com_cnt;
      w_mis_cnt_d = r_mis_cnt;
      w_word_d    = r_word;
      w_valid_d   = r_valid;
      w_strobe_d  = 1'b0;
      case (r_state)
         HUNT: begin
            if (w_is_com) begin
               w_bit_cnt_d = '0;
               w_com_cnt_d = CW'(1);
               if (LOCK_COMS == 1) begin
                  w_state_d   = LOCKED;
                  w_mis_cnt_d = '0;
                  w_word_d    = w_nxt;
                  w_valid_d   = 1'b0;
                  w_strobe_d  = 1'b1;
               end else begin
                  w_state_d   = SYNC;
               end
            end
         end
         SYNC: begin
            if (w_boundary) begin
               if (!w_is_com) begin
                  w_state_d   = HUNT;
                  w_com_cnt_d = '0;
               end else if (w_com_inc >= c_com_sat) begin
                  // Lock edge also publishes the COM itself as the first (invalid) word.
                  w_state_d   = LOCKED;
                  w_com_cnt_d = c_com_sat;
                  w_mis_cnt_d = '0;
                  w_word_d    = w_nxt;
                  w_valid_d   = 1'b0;
                  w_strobe_d  = 1'b1;
               end else begin
                  w_com_cnt_d = w_com_inc;
               end
            end
         end
         LOCKED: begin
            if (w_boundary) begin
               w_word_d   = w_nxt;
               w_valid_d  = !w_is_com;
               w_strobe_d = 1'b1;
               if (w_is_com) w_mis_cnt_d = '0;
            end else if (w_is_com) begin
               if (w_mis_inc >= c_mis_sat) begin
                  w_state_d   = HUNT;
                  w_mis_cnt_d = c_mis_sat;
                  w_com_cnt_d = '0;
                  w_valid_d   = 1'b0;
               end else begin
                  w_mis_cnt_d = w_mis_inc;
               end
            end
         end
         default: w_state_d = HUNT;
      endcase
   end

   assign o_word   = r_word;
   assign o_valid  = r_valid;
   assign o_strobe = r_strobe;
   assign o_active = (r_state == LOCKED);

endmodule

`default_nettype wire

// File: rtl/phy_rx_deser_align.sv
// ---------------------------------------------------------------------------
// phy_rx_deser_align : LANES independent serial-to-parallel lanes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module phy_rx_deser_align
   import phy_rx_deser_align_pkg::*;
#(
   parameter int           LANES        = 4,
   parameter int           W            = 8,
   parameter logic [W-1:0] COM          = W'(COM_DEFAULT),
   parameter int           LOCK_COMS    = 4,
   parameter int           MISALIGN_MAX = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [LANES-1:0]   serial_in,
   output logic [LANES*W-1:0] data_out,
   output logic [LANES-1:0]   valid_out,
   output logic [LANES-1:0]   strobe_out,
   output logic [LANES-1:0]   active_out,
   output logic               all_active
);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      phy_rx_lane #(
         .W            (W),
         .COM          (COM),
         .LOCK_COMS    (LOCK_COMS),
         .MISALIGN_MAX (MISALIGN_MAX)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .i_bit    (serial_in[k]),
         .o_word   (data_out[k*W +: W]),
         .o_valid  (valid_out[k]),
         .o_strobe (strobe_out[k]),
         .o_active (active_out[k])
      );
   end

   assign all_active = &active_out;

endmodule

`default_nettype wire
